// File: rtl/if_prefetch_stage_pkg.sv
// rtl/if_prefetch_stage_pkg.sv - shared fetch-path widths and instruction alignment constant
package if_prefetch_stage_pkg;

  // Default PC/address and instruction widths shared across the pipeline
  localparam int ADDRESS_LEN_DEFAULT     = 32;
  localparam int INSTRUCTION_LEN_DEFAULT = 32;

  // Byte distance between consecutive instructions (sequential fetch and PC+4)
  localparam int INSTR_ALIGN = 4;

endpackage

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - synchronous prefetch queue with flush (flush beats push)
module if_fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop needs a valid entry; a push needs room unless the head leaves the same cycle
  always_comb begin
    do_pop  = pop & (count != '0);
    do_push = push & ~flush & ((count < CW'(DEPTH)) | do_pop);
  end

  // Storage array; cleared on reset so the head reads zero until the first push
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy; flush empties the queue regardless of push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/if_prefetch_stage.sv
// rtl/if_prefetch_stage.sv - fetch stage with prefetch queue; IF_PERF_CNT_EN adds fetch/flush counters
module if_prefetch_stage
  import if_prefetch_stage_pkg::*;
#(
  parameter int                 ADDRESS_LEN     = ADDRESS_LEN_DEFAULT,
  parameter int                 INSTRUCTION_LEN = INSTRUCTION_LEN_DEFAULT,
  parameter int                 FIFO_DEPTH      = 4,
  parameter logic [ADDRESS_LEN-1:0] RESET_PC    = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       freeze,
  input  logic                       Branch_taken,
  input  logic [ADDRESS_LEN-1:0]     BranchAddr,
  output logic                       imem_req,
  output logic [ADDRESS_LEN-1:0]     imem_addr,
  input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
  output logic                       out_valid,
  output logic [INSTRUCTION_LEN-1:0] Instruction,
  output logic [ADDRESS_LEN-1:0]     PC
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                fetch_count,
  output logic [31:0]                flush_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int QW = INSTRUCTION_LEN + ADDRESS_LEN;

  logic [ADDRESS_LEN-1:0] pc;
  logic                   inflight;
  logic [ADDRESS_LEN-1:0] inflight_addr;
  logic [CW-1:0]          count;
  logic [CW:0]            credit_used;
  logic                   pop;
  logic                   push;
  logic [QW-1:0]          head;
  logic [QW-1:0]          push_data;

  // Issue only while queue entries plus the outstanding fetch leave a free slot;
  // a same-cycle pop is deliberately not credited so the queue cannot overflow
  always_comb begin
    credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
    imem_req    = ~rst & ~Branch_taken & (credit_used < (CW + 1)'(FIFO_DEPTH));
    imem_addr   = pc;
    out_valid   = (count != '0);
    pop         = out_valid & ~freeze;
    push        = inflight & ~Branch_taken;
    push_data   = {imem_rdata, inflight_addr + ADDRESS_LEN'(INSTR_ALIGN)};
    Instruction = head[QW-1:ADDRESS_LEN];
    PC          = head[ADDRESS_LEN-1:0];
  end

  // Fetch pointer and in-flight tracking; a redirect drops the outstanding fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC;
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else if (Branch_taken) begin
      pc       <= BranchAddr;
      inflight <= 1'b0;
    end else if (imem_req) begin
      pc            <= pc + ADDRESS_LEN'(INSTR_ALIGN);
      inflight      <= 1'b1;
      inflight_addr <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  if_fetch_fifo #(
    .WIDTH (QW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (Branch_taken),
    .wdata (push_data),
    .rdata (head),
    .count (count)
  );

`ifdef IF_PERF_CNT_EN
  // Consumed-instruction and branch-cycle counters, free-running modulo 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (pop)          fetch_count <= fetch_count + 32'd1;
      if (Branch_taken) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_prefetch_stage.sv
// tb/tb_if_prefetch_stage.sv - scoreboard bench for if_prefetch_stage
module tb_if_prefetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        Branch_taken = 1'b0;
  logic [31:0] BranchAddr = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] Instruction;
  logic [31:0] PC;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] flush_count;
`endif

  if_prefetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .Branch_taken (Branch_taken),
    .BranchAddr   (BranchAddr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .out_valid    (out_valid),
    .Instruction  (Instruction),
    .PC           (PC)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_count  (fetch_count),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: word at address a is a, returned one cycle after the request
  always @(posedge clk) imem_rdata <= imem_addr;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] next_exp = '0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the consumed stream is start, start+4, ... restarting at each redirect
  task automatic refill();
    while (exp_q.size() < 16) begin
      exp_q.push_back(next_exp);
      next_exp = next_exp + 32'd4;
    end
  endtask

  task automatic redirect(input logic [31:0] a);
    exp_q.delete();
    next_exp = a;
    refill();
  endtask

  task automatic cyc(input logic fr, input logic br, input logic [31:0] ba);
    @(posedge clk);
    #1;
    freeze = fr;
    Branch_taken = br;
    BranchAddr = ba;
    if (br) redirect(ba);
    else refill();
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    freeze = 1'b0;
    Branch_taken = 1'b0;
    redirect(32'h0);
    @(negedge clk);
  endtask

  // Monitor: every consumed head word is compared against the scoreboard
  always @(negedge clk) begin
    if (mon_en && !rst && out_valid && !freeze && !Branch_taken) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("sb_instr", Instruction, e);
        check("sb_pc", PC, e + 32'd4);
      end
    end
  end

  initial begin
    logic        fr;
    logic        br;
    logic [31:0] ba;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check("rst_instr", Instruction, 32'd0);
    check("rst_pc", PC, 32'd0);

    mon_en = 1'b1;
    release_reset();
    check("c0_req", {31'd0, imem_req}, 32'd1);
    check("c0_addr", imem_addr, 32'd0);
    check("c0_valid", {31'd0, out_valid}, 32'd0);
    cyc(1'b0, 1'b0, '0);
    check("c1_addr", imem_addr, 32'd4);
    check("c1_valid", {31'd0, out_valid}, 32'd0);
    cyc(1'b0, 1'b0, '0);
    check("c2_valid", {31'd0, out_valid}, 32'd1);
    check("c2_pc", PC, 32'd4);
    check("c2_addr", imem_addr, 32'd8);

    // Freeze cycles 3..12: fetch stops once credit is used up, head holds word 4
    for (int i = 3; i <= 12; i++) cyc(1'b1, 1'b0, '0);
    check("frz_req", {31'd0, imem_req}, 32'd0);
    check("frz_instr", Instruction, 32'd4);
    check("frz_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 13; i <= 22; i++) begin
      cyc(1'b0, 1'b0, '0);
      check("rel_valid", {31'd0, out_valid}, 32'd1);
    end

    // Branch while frozen with a fetch outstanding
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 32'h100);
    check("br_req_b", {31'd0, imem_req}, 32'd0);
    cyc(1'b1, 1'b0, '0);
    check("br_req_b1", {31'd0, imem_req}, 32'd1);
    check("br_addr_b1", imem_addr, 32'h100);
    check("br_valid_b1", {31'd0, out_valid}, 32'd0);
    cyc(1'b1, 1'b0, '0);
    check("br_valid_b2", {31'd0, out_valid}, 32'd0);
    cyc(1'b1, 1'b0, '0);
    check("br_valid_b3", {31'd0, out_valid}, 32'd1);
    check("br_instr_b3", Instruction, 32'h100);
    check("br_pc_b3", PC, 32'h104);
    repeat (4) cyc(1'b0, 1'b0, '0);

    // Branch in steady state, coinciding with a push and a pop
    cyc(1'b0, 1'b1, 32'h200);
    cyc(1'b0, 1'b0, '0);
    check("br2_valid_b1", {31'd0, out_valid}, 32'd0);
    cyc(1'b0, 1'b0, '0);
    check("br2_valid_b2", {31'd0, out_valid}, 32'd0);
    cyc(1'b0, 1'b0, '0);
    check("br2_pc_b3", PC, 32'h204);

    // Address wrap past 0xFFFFFFFC
    cyc(1'b0, 1'b1, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b0, '0);
    check("wr_addr_b1", imem_addr, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b0, '0);
    check("wr_addr_b2", imem_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, '0);
    check("wr_addr_b3", imem_addr, 32'h0);
    check("wr_pc_b3", PC, 32'hFFFF_FFFC);
    cyc(1'b0, 1'b0, '0);
    check("wr_pc_b4", PC, 32'h0);
    check("wr_instr_b4", Instruction, 32'hFFFF_FFFC);

    // Randomized freeze/branch traffic
    for (int i = 0; i < 3000; i++) begin
      fr = ($urandom_range(0, 9) < 4);
      br = ($urandom_range(0, 19) == 0);
      ba = $urandom & 32'hFFFF_FFFC;
      cyc(fr, br, ba);
      if (br) check("rnd_br_req", {31'd0, imem_req}, 32'd0);
    end

    // Asynchronous reset between edges
    cyc(1'b0, 1'b0, '0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_req", {31'd0, imem_req}, 32'd0);
    check("arst_instr", Instruction, 32'd0);
    check("arst_pc", PC, 32'd0);
    @(negedge clk);
    check("arst_req_hold", {31'd0, imem_req}, 32'd0);
    release_reset();
    check("arst_c0_addr", imem_addr, 32'd0);
    check("arst_c0_req", {31'd0, imem_req}, 32'd1);
`ifdef IF_PERF_CNT_EN
    check("arst_fetch_cnt", fetch_count, 32'd0);
    check("arst_flush_cnt", flush_count, 32'd0);
`endif
    cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, '0);
    check("arst_c2_valid", {31'd0, out_valid}, 32'd1);
    check("arst_c2_pc", PC, 32'd4);
    repeat (6) cyc(1'b0, 1'b0, '0);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
